xbar_bank_req_issue: RTL

- Crossbar-side initiator for one bank's HTU request port. It drives the xbar_bank_htu_* valid/allowIn request interface that bank_top consumes.
- It collects requests from 4 channel sources and buffers each one in a 2-entry FIFO.
- It arbitrates round-robin across channels and presents one request per cycle to the bank through an output register.
- The design instantiates one copy per bank.

---
 rtl/xbar_bank_pkg.sv | 25 ++
 rtl/xbar_req_fifo2.sv | 35 +++
 rtl/xbar_bank_req_issue.sv | 72 +++++++
 3 files changed

// File: rtl/xbar_bank_pkg.sv
// xbar_bank_pkg: shared widths, request payload type and round-robin pick for the bank request issuer
package xbar_bank_pkg;
  localparam int NUM_CH = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int CH_ID_W = 2;
  localparam int OPCODE_W = 2;
  localparam int ADDR_HI = 31;
  localparam int ADDR_LO = 4;
  localparam int ADDR_W = ADDR_HI - ADDR_LO + 1;
  localparam int WBID_W = 8;
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0] addr;
    logic [WBID_W-1:0] wbuffer_id;
  } req_payload_t;
  // Returns {hit, index} of the first requester at or after ptr, wrapping modulo NUM_CH
  function automatic logic [CH_ID_W:0] rr_pick(input logic [NUM_CH-1:0] req, input logic [CH_ID_W-1:0] ptr);
    logic [CH_ID_W-1:0] idx;
    rr_pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = ptr + CH_ID_W'(i);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction
endpackage

// File: rtl/xbar_req_fifo2.sv
// xbar_req_fifo2: two-entry request payload FIFO with wrap-around pointers and a 2-bit count
module xbar_req_fifo2
  import xbar_bank_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_push,
  input  req_payload_t i_data,
  input  logic         i_pop,
  output req_payload_t o_data,
  output logic         o_empty,
  output logic         o_full
);
  req_payload_t r_mem [FIFO_DEPTH];
  logic r_wr_ptr;
  logic r_rd_ptr;
  logic [1:0] r_count;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= !r_wr_ptr;
      if (i_pop) r_rd_ptr <= !r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end
  assign o_data = r_mem[r_rd_ptr];
  assign o_empty = r_count == 2'd0;
  assign o_full = r_count == 2'(FIFO_DEPTH);
endmodule

// File: rtl/xbar_bank_req_issue.sv
// xbar_bank_req_issue: buffers four channel request streams and issues them round-robin to one bank
module xbar_bank_req_issue
  import xbar_bank_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            ch_req_valid_i,
  output logic [NUM_CH-1:0]            ch_req_allowIn_o,
  input  logic [NUM_CH*OPCODE_W-1:0]   ch_req_opcode_i,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_req_addr_i,
  input  logic [NUM_CH*WBID_W-1:0]     ch_req_wbuffer_id_i,
  output logic                         xbar_bank_htu_valid_o,
  input  logic                         xbar_bank_htu_allowIn_i,
  output logic [CH_ID_W-1:0]           xbar_bank_htu_ch_id_o,
  output logic [OPCODE_W-1:0]          xbar_bank_htu_opcode_o,
  output logic [ADDR_W-1:0]            xbar_bank_htu_addr_o,
  output logic [WBID_W-1:0]            xbar_bank_htu_wbuffer_id_o
);
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_full;
  req_payload_t w_head [NUM_CH];
  logic w_load;
  logic w_hit;
  logic [CH_ID_W-1:0] w_gnt;
  logic [CH_ID_W-1:0] r_ptr;
  logic r_valid;
  logic [CH_ID_W-1:0] r_ch_id;
  req_payload_t r_pl;
  genvar c;
  for (c = 0; c < NUM_CH; c++) begin : g_ch
    req_payload_t w_in;
    assign w_in = {ch_req_opcode_i[OPCODE_W*c +: OPCODE_W], ch_req_addr_i[ADDR_W*c +: ADDR_W], ch_req_wbuffer_id_i[WBID_W*c +: WBID_W]};
    assign w_push[c] = ch_req_valid_i[c] && !w_full[c];
    xbar_req_fifo2 u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_push  (w_push[c]),
      .i_data  (w_in),
      .i_pop   (w_pop[c]),
      .o_data  (w_head[c]),
      .o_empty (w_empty[c]),
      .o_full  (w_full[c])
    );
  end
  assign ch_req_allowIn_o = ~w_full;
  assign w_load = !r_valid || xbar_bank_htu_allowIn_i;
  assign {w_hit, w_gnt} = rr_pick(~w_empty, r_ptr);
  assign w_pop = (w_load && w_hit) ? NUM_CH'(1) << w_gnt : '0;
  // Payload registers only move on a grant so an idle output keeps its last value
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_ch_id <= '0;
      r_pl <= '0;
      r_ptr <= '0;
    end else if (w_load) begin
      r_valid <= w_hit;
      if (w_hit) begin
        r_ch_id <= w_gnt;
        r_pl <= w_head[w_gnt];
        r_ptr <= w_gnt + 1'b1;
      end
    end
  end
  assign xbar_bank_htu_valid_o = r_valid;
  assign xbar_bank_htu_ch_id_o = r_ch_id;
  assign xbar_bank_htu_opcode_o = r_pl.opcode;
  assign xbar_bank_htu_addr_o = r_pl.addr;
  assign xbar_bank_htu_wbuffer_id_o = r_pl.wbuffer_id;
endmodule
